i2c_slave_ctrl: RTL

- Sequencing FSM for the I2C slave transmit path.
- Consumes START/STOP and SCL edge pulses from the edge/start-stop detectors, plus address-match and R/W results from the RX shift register.
- Produces rx/tx shift enables, TX load, FIFO read pop, and the 2-bit mode that drives the SDA output select.
- Supports master-read transactions only; address mismatch or write requests are NACKed.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_slave_ctrl_flex_counter.sv | 31 +++
 rtl/i2c_slave_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// Shared types for the I2C slave transmit-path controller: FSM states,
// SDA output-select codes and the state-to-SDA-mode decode.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE, RX_ADDR, ADDR_CHK, ACK_ADDR, ACK_HOLD, NACK_ADDR, NACK_HOLD,
    LOAD, TX_BYTE, MACK_WAIT, MACK_HOLD
  } state_t;

  localparam logic [1:0] SDA_IDLE = 2'b00;
  localparam logic [1:0] SDA_ACK  = 2'b01;
  localparam logic [1:0] SDA_NACK = 2'b10;
  localparam logic [1:0] SDA_TX   = 2'b11;

  function automatic logic [1:0] sda_of(state_t s);
    case (s)
      ACK_ADDR, ACK_HOLD:   return SDA_ACK;
      NACK_ADDR, NACK_HOLD: return SDA_NACK;
      LOAD, TX_BYTE:        return SDA_TX;
      default:              return SDA_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/i2c_slave_ctrl_flex_counter.sv
// Saturating up-counter: stops at rollover_val, rollover_flag is high while
// the count sits there. Synchronous active-low reset, clear beats enable.
module flex_counter #(
  parameter int NUM_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                clear,
  input  logic                count_enable,
  input  logic [NUM_BITS-1:0] rollover_val,
  output logic [NUM_BITS-1:0] count_out,
  output logic                rollover_flag
);

  logic [NUM_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)                                   cnt_d = '0;
    else if (count_enable && cnt_q != rollover_val) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count_out     = cnt_q;
  assign rollover_flag = (cnt_q == rollover_val);

endmodule

// File: rtl/i2c_slave_ctrl.sv
// I2C slave transmit-path sequencer (master-read only; writes and foreign
// addresses are NACKed). Define I2C_CTRL_TIMEOUT_EN for the idle-bus timeout.
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter int BITS_PER_BYTE  = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start_found,
  input  logic       stop_found,
  input  logic       rising_edge_found,
  input  logic       falling_edge_found,
  input  logic       address_match,
  input  logic       rw_mode,
  input  logic       sda_in,
  input  logic       fifo_empty,
  output logic       rx_enable,
  output logic       tx_enable,
  output logic       load_data,
  output logic       read_enable,
  output logic [1:0] sda_mode,
  output logic       busy
);

  localparam int CNT_W = $clog2(BITS_PER_BYTE + 1);
  localparam logic [CNT_W-1:0] BYTE_END = CNT_W'(BITS_PER_BYTE);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BITS_PER_BYTE - 1);

  state_t           state_q, state_d;
  logic             ack_flag_q;
  logic [CNT_W-1:0] bit_cnt;
  logic             byte_full, cnt_clr, cnt_en, timeout;

  assign cnt_clr = start_found || state_q == IDLE || state_q == LOAD;
  assign cnt_en  = (state_q == RX_ADDR && rising_edge_found) ||
                   (state_q == TX_BYTE && falling_edge_found);

  flex_counter #(.NUM_BITS(CNT_W)) u_bit_cnt (
    .clk(clk), .n_rst(n_rst), .clear(cnt_clr), .count_enable(cnt_en),
    .rollover_val(BYTE_END), .count_out(bit_cnt), .rollover_flag(byte_full)
  );

`ifdef I2C_CTRL_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic            to_clr;
  logic [TO_W-1:0] to_cnt_unused;

  assign to_clr = rising_edge_found || falling_edge_found || start_found ||
                  stop_found || state_q == IDLE;

  flex_counter #(.NUM_BITS(TO_W)) u_timeout (
    .clk(clk), .n_rst(n_rst), .clear(to_clr), .count_enable(1'b1),
    .rollover_val(TO_W'(TIMEOUT_CYCLES - 1)), .count_out(to_cnt_unused),
    .rollover_flag(timeout)
  );
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    if (timeout || stop_found) state_d = IDLE;
    else if (start_found)      state_d = RX_ADDR;
    else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        RX_ADDR:   if (falling_edge_found && byte_full) state_d = ADDR_CHK;
        ADDR_CHK:  state_d = (address_match && rw_mode) ? ACK_ADDR : NACK_ADDR;
        ACK_ADDR:  if (rising_edge_found)  state_d = ACK_HOLD;
        ACK_HOLD:  if (falling_edge_found) state_d = LOAD;
        NACK_ADDR: if (rising_edge_found)  state_d = NACK_HOLD;
        NACK_HOLD: if (falling_edge_found) state_d = IDLE;
        LOAD:      state_d = TX_BYTE;
        // The falling edge that completes the last bit leaves the byte now.
        TX_BYTE:   if (falling_edge_found && bit_cnt == LAST_BIT) state_d = MACK_WAIT;
        MACK_WAIT: if (rising_edge_found)  state_d = MACK_HOLD;
        MACK_HOLD: if (falling_edge_found) state_d = ack_flag_q ? LOAD : IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they track state_q exactly.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      ack_flag_q  <= 1'b0;
      rx_enable   <= 1'b0;
      tx_enable   <= 1'b0;
      load_data   <= 1'b0;
      read_enable <= 1'b0;
      sda_mode    <= SDA_IDLE;
      busy        <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == MACK_WAIT && rising_edge_found) ack_flag_q <= !sda_in;
      rx_enable   <= (state_d == RX_ADDR);
      tx_enable   <= (state_d == TX_BYTE);
      load_data   <= (state_d == LOAD);
      read_enable <= (state_d == LOAD) && !fifo_empty;
      sda_mode    <= sda_of(state_d);
      busy        <= (state_d != IDLE);
    end
  end

endmodule
